// File: rtl/analog_scan_ctrl.sv
// Analog mux scan controller: walks a latched channel mask with break-before-make switching,
// a per-channel settle delay and a sample handshake, with optional continuous wrap-around.
module analog_scan_ctrl #(
    parameter int unsigned NCH = 6,
    parameter int unsigned SW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           start,
    input  logic           abort,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    input  logic [SW-1:0]  settle,
    input  logic           sample_ack,
    output logic [2:0]     sel,
    output logic           mux_en,
    output logic           sample_req,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StSettle,
        StSample,
        StNext
    } state_e;

    state_e         r_state, w_state_nxt;
    logic [2:0]     r_sel, w_sel_nxt;
    logic           r_cont, w_cont_nxt;
    logic [NCH-1:0] r_mask, w_mask_nxt;
    logic [SW-1:0]  r_settle, w_settle_nxt;
    logic [SW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_done, w_done_nxt;

    logic [2:0]     w_in_low;
    logic           w_in_found;
    logic [2:0]     w_lat_low;
    logic           w_lat_found;
    logic [2:0]     w_above_idx;
    logic           w_above_found;
    logic [SW-1:0]  w_one;
    logic [SW-1:0]  w_settle_eff;

    assign w_one        = {{(SW-1){1'b0}}, 1'b1};
    // A zero settle request still gets one settle cycle.
    assign w_settle_eff = (r_settle == '0) ? w_one : r_settle;

    // Lowest set bit of the live mask (scan start) and of the latched mask (wrap-around).
    always_comb begin
        w_in_low    = '0;
        w_in_found  = 1'b0;
        w_lat_low   = '0;
        w_lat_found = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (ch_mask[i] && !w_in_found) begin
                w_in_low   = 3'(i);
                w_in_found = 1'b1;
            end
            if (r_mask[i] && !w_lat_found) begin
                w_lat_low   = 3'(i);
                w_lat_found = 1'b1;
            end
        end
    end

    // Next latched channel strictly above the current one.
    always_comb begin
        w_above_idx   = '0;
        w_above_found = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (r_mask[i] && !w_above_found && (i > int'(r_sel))) begin
                w_above_idx   = 3'(i);
                w_above_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cont_nxt   = r_cont;
        w_mask_nxt   = r_mask;
        w_settle_nxt = r_settle;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start && !abort) begin
                    if (w_in_found) begin
                        w_state_nxt  = StBreak;
                        w_sel_nxt    = w_in_low;
                        w_cont_nxt   = cont;
                        w_mask_nxt   = ch_mask;
                        w_settle_nxt = settle;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            StBreak: begin
                w_state_nxt = StSettle;
                w_cnt_nxt   = w_settle_eff;
            end
            StSettle: begin
                if (r_cnt <= w_one) begin
                    w_state_nxt = StSample;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - w_one;
                end
            end
            StSample: begin
                if (sample_ack) begin
                    w_state_nxt = StNext;
                end
            end
            StNext: begin
                if (w_above_found) begin
                    w_state_nxt = StBreak;
                    w_sel_nxt   = w_above_idx;
                end else if (r_cont) begin
                    w_state_nxt = StBreak;
                    w_sel_nxt   = w_lat_low;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Abort overrides every other transition and suppresses the pass-complete pulse.
        if (abort && (r_state != StIdle)) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_sel    <= '0;
            r_cont   <= 1'b0;
            r_mask   <= '0;
            r_settle <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (ena) begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cont   <= w_cont_nxt;
            r_mask   <= w_mask_nxt;
            r_settle <= w_settle_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign sel        = r_sel;
    assign mux_en     = (r_state == StSettle) || (r_state == StSample) || (r_state == StNext);
    assign sample_req = (r_state == StSample);
    assign busy       = (r_state != StIdle);
    assign done       = r_done;

endmodule

// File: tb/tb_analog_scan_ctrl.sv
// Scoreboard bench for analog_scan_ctrl: expected (channel, settle length) pairs are queued
// at scan start and popped as each sample request rises; timing is checked by a cycle monitor.
module tb_analog_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       abort;
    logic       cont;
    logic [5:0] ch_mask;
    logic [7:0] settle;
    logic       sample_ack;
    logic [2:0] sel;
    logic       mux_en;
    logic       sample_req;
    logic       busy;
    logic       done;

    analog_scan_ctrl #(
        .NCH(6),
        .SW (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .abort     (abort),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .settle    (settle),
        .sample_ack(sample_ack),
        .sel       (sel),
        .mux_en    (mux_en),
        .sample_req(sample_req),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        int         settle;
    } exp_t;

    exp_t exp_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt, busy_seen, mux_seen, brk_run, settle_run, req_run;
    logic prev_req, prev_mux;
    logic auto_ack;
    logic exp_done_busy;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr();
        done_cnt   = 0;
        busy_seen  = 0;
        mux_seen   = 0;
        brk_run    = 0;
        settle_run = 0;
        req_run    = 0;
        prev_req   = 1'b0;
        prev_mux   = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] s, input int n);
        exp_t e;
        e.sel    = s;
        e.settle = n;
        exp_q.push_back(e);
    endtask

    // One clock: observe outputs just after the edge, score them, drive the ack responder.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_seen++;
        if (mux_en === 1'b1) mux_seen++;
        if (done === 1'b1) begin
            done_cnt++;
            check_eq("done_busy", 32'(busy), 32'(exp_done_busy));
        end
        if (sample_req === 1'b1 && !prev_req) begin
            if (exp_q.size() == 0) begin
                check_eq("req_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("req_sel", 32'(sel), 32'(e.sel));
                check_eq("settle_len", 32'(settle_run), 32'(e.settle));
            end
            req_run = 0;
        end
        if (sample_req === 1'b1) req_run++;
        if (sample_req === 1'b0 && prev_req && auto_ack) begin
            check_eq("req_len", 32'(req_run), 32'd2);
        end
        if (mux_en === 1'b1 && !prev_mux && busy === 1'b1) begin
            check_eq("break_len", 32'(brk_run), 32'd1);
            brk_run = 0;
        end
        if (busy === 1'b1 && mux_en === 1'b0) brk_run++;
        else if (busy !== 1'b1) brk_run = 0;
        if (mux_en === 1'b1 && sample_req !== 1'b1) settle_run++;
        else if (mux_en !== 1'b1) settle_run = 0;
        if (auto_ack) sample_ack = (sample_req === 1'b1) && (req_run >= 2);
        prev_req = (sample_req === 1'b1);
        prev_mux = (mux_en === 1'b1);
    endtask

    // Pulse start, then scramble the latched inputs to show they no longer matter.
    task automatic start_scan(input logic [5:0] m, input logic [7:0] s, input logic c);
        ch_mask = m;
        settle  = s;
        cont    = c;
        start   = 1'b1;
        step();
        start   = 1'b0;
        ch_mask = 6'($urandom);
        settle  = 8'($urandom_range(0, 20));
        cont    = ~c;
    endtask

    task automatic run_until_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_eq("done_reached", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cont          = 1'b0;
        ch_mask       = '0;
        settle        = '0;
        sample_ack    = 1'b0;
        auto_ack      = 1'b0;
        exp_done_busy = 1'b0;
        clr();

        // Reset wins even with ena low.
        step();
        step();
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_mux_en", 32'(mux_en), 32'd0);
        check_eq("rst_req", 32'(sample_req), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst_n    = 1'b1;
        ena      = 1'b1;
        auto_ack = 1'b1;
        step();

        // Two-channel single pass; a start while busy must be ignored.
        clr();
        exp_done_busy = 1'b0;
        push_exp(3'd0, 3);
        push_exp(3'd2, 3);
        start_scan(6'b000101, 8'd3, 1'b0);
        check_eq("s1_first_sel", 32'(sel), 32'd0);
        check_eq("s1_break_busy", 32'(busy), 32'd1);
        check_eq("s1_break_mux", 32'(mux_en), 32'd0);
        start   = 1'b1;
        ch_mask = 6'b111111;
        step();
        start = 1'b0;
        run_until_done(1, 60);
        check_eq("s1_queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        step();
        check_eq("s1_done_once", 32'(done_cnt), 32'd1);
        check_eq("s1_idle_sel", 32'(sel), 32'd2);

        // Single channel, continuous, zero settle treated as one.
        clr();
        exp_done_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(3'd5, 1);
        start_scan(6'b100000, 8'd0, 1'b1);
        run_until_done(3, 60);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("s2_abort_busy", 32'(busy), 32'd0);
        step();
        step();
        check_eq("s2_no_extra_done", 32'(done_cnt), 32'd3);
        check_eq("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Multi-channel continuous scan wraps to the lowest latched bit.
        clr();
        exp_done_busy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push_exp(3'd1, 2);
            push_exp(3'd2, 2);
            push_exp(3'd4, 2);
        end
        start_scan(6'b010110, 8'd2, 1'b1);
        run_until_done(2, 100);
        check_eq("s3_wrap_sel", 32'(sel), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("s3_abort_mux", 32'(mux_en), 32'd0);
        check_eq("s3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Empty mask: one done pulse, never busy.
        clr();
        exp_done_busy = 1'b0;
        start_scan(6'b000000, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_eq("s4_done_once", 32'(done_cnt), 32'd1);
        check_eq("s4_busy_never", 32'(busy_seen), 32'd0);
        check_eq("s4_mux_never", 32'(mux_seen), 32'd0);

        // Abort during settle, then a fresh scan starts at the lowest bit.
        clr();
        start_scan(6'b001010, 8'd4, 1'b0);
        step();
        step();
        step();
        check_eq("s5_in_settle", 32'(mux_en), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("s5_abort_busy", 32'(busy), 32'd0);
        check_eq("s5_abort_mux", 32'(mux_en), 32'd0);
        check_eq("s5_abort_done", 32'(done), 32'd0);
        step();
        step();
        check_eq("s5_no_done", 32'(done_cnt), 32'd0);
        clr();
        exp_done_busy = 1'b0;
        push_exp(3'd1, 1);
        push_exp(3'd3, 1);
        start_scan(6'b001010, 8'd1, 1'b0);
        check_eq("s5_restart_sel", 32'(sel), 32'd1);
        run_until_done(1, 40);
        check_eq("s5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Freeze for five cycles mid-settle; the settle window stretches by exactly that.
        clr();
        exp_done_busy = 1'b0;
        push_exp(3'd0, 9);
        start_scan(6'b000001, 8'd4, 1'b0);
        step();
        step();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("s6_frozen_mux", 32'(mux_en), 32'd1);
            check_eq("s6_frozen_req", 32'(sample_req), 32'd0);
        end
        ena = 1'b1;
        step();
        check_eq("s6_settle3_req", 32'(sample_req), 32'd0);
        step();
        check_eq("s6_settle4_req", 32'(sample_req), 32'd0);
        step();
        check_eq("s6_sample_req", 32'(sample_req), 32'd1);
        run_until_done(1, 20);
        check_eq("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a sample request is pending; a late ack is ignored.
        clr();
        auto_ack      = 1'b0;
        sample_ack    = 1'b0;
        exp_done_busy = 1'b0;
        push_exp(3'd1, 1);
        start_scan(6'b000110, 8'd1, 1'b1);
        for (int i = 0; i < 10 && sample_req !== 1'b1; i++) step();
        check_eq("s7_req_high", 32'(sample_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("s7_rst_sel", 32'(sel), 32'd0);
        check_eq("s7_rst_mux", 32'(mux_en), 32'd0);
        check_eq("s7_rst_req", 32'(sample_req), 32'd0);
        check_eq("s7_rst_busy", 32'(busy), 32'd0);
        check_eq("s7_rst_done", 32'(done), 32'd0);
        busy_seen  = 0;
        sample_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        sample_ack = 1'b0;
        check_eq("s7_ack_ignored", 32'(busy_seen), 32'd0);
        check_eq("s7_no_done", 32'(done_cnt), 32'd0);
        check_eq("s7_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
